lc3_ctrl_fsm: RTL and testbench

Microsequencer for the LC-3 datapath. It drives the load enables, including LD_CC for the N/Z/P flag logic and LD_BEN for the branch comparator, along with bus gates, muxes and memory handshake. Supported instructions: ADD, AND, NOT, BR, JMP, LD, ST, LEA and TRAP (TRAP halts). It adds a memory-wait watchdog and a retired-instruction counter.

---
 rtl/lc3_ctrl_fsm_if.sv | 50 +++++
 rtl/lc3_ctrl_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_lc3_ctrl_fsm.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_ctrl_fsm_if.sv
// Control/status bundle between the LC-3 microsequencer (master) and the
// datapath it steers (slave).
interface lc3_ctrl_fsm_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       opcode;
  logic             ben;
  logic             mem_r;
  logic             run;

  logic             ld_mar;
  logic             ld_mdr;
  logic             ld_ir;
  logic             ld_ben;
  logic             ld_reg;
  logic             ld_cc;
  logic             ld_pc;
  logic             gate_pc;
  logic             gate_mdr;
  logic             gate_alu;
  logic             gate_marmux;
  logic [1:0]       pcmux;
  logic             addr1mux;
  logic [1:0]       addr2mux;
  logic [1:0]       aluk;
  logic             sr1mux;
  logic             mio_en;
  logic             r_w;
  logic [5:0]       state;
  logic             halted;
  logic             bus_err;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, ben, mem_r, run,
    output ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
           gate_pc, gate_mdr, gate_alu, gate_marmux,
           pcmux, addr1mux, addr2mux, aluk, sr1mux, mio_en, r_w,
           state, halted, bus_err, illegal, instr_cnt
  );

  modport slave (
    output opcode, ben, mem_r, run,
    input  ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
           gate_pc, gate_mdr, gate_alu, gate_marmux,
           pcmux, addr1mux, addr2mux, aluk, sr1mux, mio_en, r_w,
           state, halted, bus_err, illegal, instr_cnt
  );
endinterface

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 Moore microsequencer with a memory-wait watchdog (halts with a sticky
// bus error) and a retired-instruction counter.
module lc3_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 255,
  parameter int CNT_W        = 16
) (
  input logic           clk,
  input logic           rst_n,
  lc3_ctrl_fsm_if.master bus
);
  typedef enum logic [5:0] {
    S_BR       = 6'd0,
    S_ADD      = 6'd1,
    S_LD       = 6'd2,
    S_ST       = 6'd3,
    S_AND      = 6'd5,
    S_NOT      = 6'd9,
    S_JMP      = 6'd12,
    S_LEA      = 6'd14,
    S_ST_WR    = 6'd16,
    S_FETCH    = 6'd18,
    S_BR_TAKE  = 6'd22,
    S_ST_DATA  = 6'd23,
    S_LD_RD    = 6'd25,
    S_LD_WB    = 6'd27,
    S_DECODE   = 6'd32,
    S_FETCH_RD = 6'd33,
    S_FETCH_IR = 6'd35,
    S_ILL      = 6'd61,
    S_HALT     = 6'd62,
    S_RST      = 6'd63
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t           state_reg, state_next;
  logic [7:0]       wd_reg, wd_next;
  logic             bus_err_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout;
  logic             retire;
  logic             in_wait;

  // State register plus the watchdog, sticky error and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_RST;
      wd_reg      <= 8'd0;
      bus_err_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
      if (timeout) begin
        bus_err_reg <= 1'b1;
      end
      if (retire) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    in_wait    = 1'b0;
    case (state_reg)
      S_RST:      state_next = S_FETCH;
      S_FETCH:    state_next = S_FETCH_RD;
      S_FETCH_IR: state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          4'b0000: state_next = S_BR;
          4'b0001: state_next = S_ADD;
          4'b0101: state_next = S_AND;
          4'b1001: state_next = S_NOT;
          4'b1100: state_next = S_JMP;
          4'b1110: state_next = S_LEA;
          4'b0010: state_next = S_LD;
          4'b0011: state_next = S_ST;
          4'b1111: state_next = S_HALT;
          default: state_next = S_ILL;
        endcase
      end
      S_BR:       state_next = bus.ben ? S_BR_TAKE : S_FETCH;
      S_LD:       state_next = S_LD_RD;
      S_ST:       state_next = S_ST_DATA;
      S_ST_DATA:  state_next = S_ST_WR;
      S_FETCH_RD, S_LD_RD, S_ST_WR: begin
        in_wait = 1'b1;
        if (bus.mem_r) begin
          case (state_reg)
            S_FETCH_RD: state_next = S_FETCH_IR;
            S_LD_RD:    state_next = S_LD_WB;
            default:    state_next = S_FETCH;
          endcase
        end else if (wd_reg == WD_LAST) begin
          // Ready arriving on the timeout edge has already been taken above.
          state_next = S_HALT;
          timeout    = 1'b1;
        end
      end
      S_HALT:     state_next = bus.run ? S_FETCH : S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    wd_next = 8'd0;
    if (in_wait && state_next == state_reg) begin
      wd_next = wd_reg + 8'd1;
    end
  end

  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_BR, S_BR_TAKE, S_ADD, S_AND, S_NOT, S_JMP, S_LEA, S_LD_WB, S_ST_WR:
        retire = (state_next == S_FETCH);
      default: retire = 1'b0;
    endcase
  end

  // Output decode depends on the registered state alone.
  always_comb begin
    bus.ld_mar      = 1'b0;
    bus.ld_mdr      = 1'b0;
    bus.ld_ir       = 1'b0;
    bus.ld_ben      = 1'b0;
    bus.ld_reg      = 1'b0;
    bus.ld_cc       = 1'b0;
    bus.ld_pc       = 1'b0;
    bus.gate_pc     = 1'b0;
    bus.gate_mdr    = 1'b0;
    bus.gate_alu    = 1'b0;
    bus.gate_marmux = 1'b0;
    bus.pcmux       = 2'd0;
    bus.addr1mux    = 1'b0;
    bus.addr2mux    = 2'd0;
    bus.aluk        = 2'd0;
    bus.sr1mux      = 1'b0;
    bus.mio_en      = 1'b0;
    bus.r_w         = 1'b0;
    bus.halted      = 1'b0;
    bus.illegal     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        bus.ld_mar  = 1'b1;
        bus.gate_pc = 1'b1;
        bus.ld_pc   = 1'b1;
      end
      S_FETCH_RD, S_LD_RD: begin
        bus.mio_en = 1'b1;
        bus.ld_mdr = 1'b1;
      end
      S_FETCH_IR: begin
        bus.gate_mdr = 1'b1;
        bus.ld_ir    = 1'b1;
      end
      S_DECODE:  bus.ld_ben = 1'b1;
      S_BR_TAKE: begin
        bus.ld_pc    = 1'b1;
        bus.pcmux    = 2'd1;
        bus.addr2mux = 2'd2;
      end
      S_ADD, S_AND, S_NOT: begin
        bus.gate_alu = 1'b1;
        bus.ld_reg   = 1'b1;
        bus.ld_cc    = 1'b1;
        bus.sr1mux   = 1'b1;
        bus.aluk     = (state_reg == S_ADD) ? 2'd0 :
                       (state_reg == S_AND) ? 2'd1 : 2'd2;
      end
      S_JMP: begin
        bus.ld_pc    = 1'b1;
        bus.pcmux    = 2'd1;
        bus.addr1mux = 1'b1;
        bus.sr1mux   = 1'b1;
      end
      S_LEA: begin
        bus.gate_marmux = 1'b1;
        bus.addr2mux    = 2'd2;
        bus.ld_reg      = 1'b1;
        bus.ld_cc       = 1'b1;
      end
      S_LD, S_ST: begin
        bus.ld_mar      = 1'b1;
        bus.gate_marmux = 1'b1;
        bus.addr2mux    = 2'd2;
      end
      S_LD_WB: begin
        bus.gate_mdr = 1'b1;
        bus.ld_reg   = 1'b1;
        bus.ld_cc    = 1'b1;
      end
      S_ST_DATA: begin
        bus.gate_alu = 1'b1;
        bus.aluk     = 2'd3;
        bus.ld_mdr   = 1'b1;
      end
      S_ST_WR: begin
        bus.mio_en = 1'b1;
        bus.r_w    = 1'b1;
      end
      S_ILL:  bus.illegal = 1'b1;
      S_HALT: bus.halted  = 1'b1;
      default: ;
    endcase
  end

  assign bus.state     = state_reg;
  assign bus.bus_err   = bus_err_reg;
  assign bus.instr_cnt = cnt_reg;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Instruction-level scoreboard bench: each instruction expands into its state
// path, a driver replays the inputs and a monitor compares every cycle.
module tb_lc3_ctrl_fsm;
  localparam int MAX   = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc3_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

  lc3_ctrl_fsm #(.MEM_WAIT_MAX(MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] opcode;
    logic       ben;
    logic       mem_r;
    logic       run;
  } stim_t;

  typedef struct packed {
    logic [5:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             berr;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    m_cnt  = 0;
  bit    m_berr = 1'b0;
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  bit    active = 1'b0;

  wire [22:0] dut_ctrl = {bus.ld_mar, bus.ld_mdr, bus.ld_ir, bus.ld_ben, bus.ld_reg,
                          bus.ld_cc, bus.ld_pc, bus.gate_pc, bus.gate_mdr, bus.gate_alu,
                          bus.gate_marmux, bus.pcmux, bus.addr1mux, bus.addr2mux,
                          bus.aluk, bus.sr1mux, bus.mio_en, bus.r_w, bus.halted,
                          bus.illegal};
  wire [3:0]  gates = {bus.gate_pc, bus.gate_mdr, bus.gate_alu, bus.gate_marmux};

  // Control table: which signals each state is documented to assert.
  function automatic logic [22:0] ctrl_of(input logic [5:0] s);
    logic ld_mar = 0, ld_mdr = 0, ld_ir = 0, ld_ben = 0, ld_reg = 0, ld_cc = 0, ld_pc = 0;
    logic g_pc = 0, g_mdr = 0, g_alu = 0, g_mm = 0, a1 = 0, sr1 = 0, mio = 0, rw = 0;
    logic hlt = 0, ill = 0;
    logic [1:0] pcm = 0, a2 = 0, alu = 0;
    case (s)
      6'd18: begin ld_mar = 1; g_pc = 1; ld_pc = 1; end
      6'd33, 6'd25: begin mio = 1; ld_mdr = 1; end
      6'd35: begin g_mdr = 1; ld_ir = 1; end
      6'd32: ld_ben = 1;
      6'd22: begin ld_pc = 1; pcm = 1; a2 = 2; end
      6'd1:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; alu = 0; end
      6'd5:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; alu = 1; end
      6'd9:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; alu = 2; end
      6'd12: begin ld_pc = 1; pcm = 1; a1 = 1; sr1 = 1; end
      6'd14: begin g_mm = 1; a2 = 2; ld_reg = 1; ld_cc = 1; end
      6'd2, 6'd3: begin ld_mar = 1; g_mm = 1; a2 = 2; end
      6'd27: begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
      6'd23: begin g_alu = 1; alu = 3; ld_mdr = 1; end
      6'd16: begin mio = 1; rw = 1; end
      6'd61: ill = 1;
      6'd62: hlt = 1;
      default: ;
    endcase
    return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc, g_pc, g_mdr, g_alu, g_mm,
            pcm, a1, a2, alu, sr1, mio, rw, hlt, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_full(input logic [5:0] s, input logic [3:0] op, input bit ben,
                          input bit mem_r, input bit run);
    stim_t st;
    exp_t  ex;
    st = '{opcode: op, ben: ben, mem_r: mem_r, run: run};
    ex = '{state: s, cnt: CNT_W'(m_cnt), berr: m_berr};
    stim_q.push_back(st);
    exp_q.push_back(ex);
  endtask

  task automatic add_w(input logic [5:0] s, input bit mem_r);
    add_full(s, 4'($urandom_range(0, 15)), 1'($urandom), mem_r, 1'($urandom));
  endtask

  task automatic add(input logic [5:0] s);
    add_w(s, 1'($urandom));
  endtask

  // A wait of MAX or more low cycles exhausts the watchdog after MAX cycles.
  task automatic mem_wait(input logic [5:0] s, input int w, input bit retire_on_done,
                          output bit ok);
    if (w >= MAX) begin
      for (int i = 0; i < MAX; i++) add_w(s, 1'b0);
      m_berr = 1'b1;
      ok = 1'b0;
    end else begin
      for (int i = 0; i < w; i++) add_w(s, 1'b0);
      add_w(s, 1'b1);
      if (retire_on_done) m_cnt++;
      ok = 1'b1;
    end
  endtask

  task automatic halt(input int hold);
    for (int i = 0; i < hold; i++)
      add_full(6'd62, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'b0);
    add_full(6'd62, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic run_instr(input logic [3:0] op, input bit ben, input int fw,
                           input int dw, input int hold);
    bit ok;
    add(6'd18);
    mem_wait(6'd33, fw, 1'b0, ok);
    if (!ok) begin
      halt(hold);
      return;
    end
    add(6'd35);
    add_full(6'd32, op, 1'($urandom), 1'($urandom), 1'($urandom));
    case (op)
      4'b0000: begin
        add_full(6'd0, 4'($urandom_range(0, 15)), ben, 1'($urandom), 1'($urandom));
        if (ben) add(6'd22);
        m_cnt++;
      end
      4'b0001: begin add(6'd1);  m_cnt++; end
      4'b0101: begin add(6'd5);  m_cnt++; end
      4'b1001: begin add(6'd9);  m_cnt++; end
      4'b1100: begin add(6'd12); m_cnt++; end
      4'b1110: begin add(6'd14); m_cnt++; end
      4'b0010: begin
        add(6'd2);
        mem_wait(6'd25, dw, 1'b0, ok);
        if (ok) begin
          add(6'd27);
          m_cnt++;
        end else begin
          halt(hold);
        end
      end
      4'b0011: begin
        add(6'd3);
        add(6'd23);
        mem_wait(6'd16, dw, 1'b1, ok);
        if (!ok) halt(hold);
      end
      4'b1111: halt(hold);
      default: add(6'd61);
    endcase
  endtask

  function automatic int rnd_wait();
    if ($urandom_range(0, 7) == 0) return $urandom_range(0, MAX + 1);
    return $urandom_range(0, 2);
  endfunction

  // Driver: replays one stimulus entry per cycle, just after the edge.
  initial begin
    stim_t s;
    forever begin
      @(posedge clk);
      if (active && stim_q.size() > 0) begin
        #1;
        s = stim_q.pop_front();
        bus.opcode = s.opcode;
        bus.ben    = s.ben;
        bus.mem_r  = s.mem_r;
        bus.run    = s.run;
      end
    end
  end

  // Monitor: one expected entry per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (active) begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          cyc++;
          check("state",   32'(bus.state),     32'(e.state));
          check("ctrl",    32'(dut_ctrl),      32'(ctrl_of(e.state)));
          check("cnt",     32'(bus.instr_cnt), 32'(e.cnt));
          check("bus_err", 32'(bus.bus_err),   32'(e.berr));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("gate_onehot", 32'($countones(gates) <= 1), 32'd1);
    end
  end

  initial begin
    bit done;
    bus.opcode = 4'd0;
    bus.ben    = 1'b0;
    bus.mem_r  = 1'b0;
    bus.run    = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd63);
    check("rst_ctrl",  32'(dut_ctrl),  32'd0);
    check("rst_cnt",   32'(bus.instr_cnt), 32'd0);

    run_instr(4'b0001, 1'b0, 0, 0, 0);
    run_instr(4'b0000, 1'b1, 0, 0, 0);
    run_instr(4'b0000, 1'b0, 0, 0, 0);
    run_instr(4'b0010, 1'b0, 0, 3, 0);
    run_instr(4'b0011, 1'b0, 1, MAX + 2, 2);
    run_instr(4'b1101, 1'b0, 0, 0, 0);
    run_instr(4'b1111, 1'b0, 0, 0, 3);
    for (int i = 0; i < 150; i++)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom), rnd_wait(), rnd_wait(),
                $urandom_range(0, 3));
    // Park the machine in the fetch wait so reset can land mid-wait.
    add(6'd18);
    add_w(6'd33, 1'b0);
    add_w(6'd33, 1'b0);

    rst_n  = 1'b1;
    active = 1'b1;
    done   = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      #2;
      done = (exp_q.size() == 0);
    end
    active = 1'b0;
    check("drain", 32'(exp_q.size()), 32'd0);

    rst_n = 1'b0;
    #1;
    check("async_state", 32'(bus.state),     32'd63);
    check("async_ctrl",  32'(dut_ctrl),      32'd0);
    check("async_cnt",   32'(bus.instr_cnt), 32'd0);
    check("async_berr",  32'(bus.bus_err),   32'd0);
    @(negedge clk);
    bus.mem_r = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("resume_18", 32'(bus.state), 32'd18);
    @(negedge clk);
    check("resume_33", 32'(bus.state), 32'd33);
    check("resume_cnt", 32'(bus.instr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
